apb_master_arbiter: RTL and testbench
=====================================

# apb_master_arbiter

Shares one APB3 master port between `NREQ` local requesters and sequences each transfer through SETUP and ACCESS phases. It sits in front of the APB slave memory and is its only bus master. Arbitration is round-robin, with one transfer in flight at a time. A timeout terminates transfers that are never acknowledged.

## Interface
- `NREQ`, 4: number of requesters (2..8)
- `AW`, 32: address width
- `DW`, 32: data width
- `TIMEOUT`, 16: max ACCESS cycles with `pready` low before forced termination (≥1)

Ports:
- `pclk` in 1: the single clock; all logic is on the rising edge
- `prst` in 1: reset; synchronous, active-high
- `req` in NREQ: per-requester transfer request; held high until that requester's `done` bit pulses
- `req_write` in NREQ: 1 = write, 0 = read
- `req_addr` in NREQ*AW: packed addresses; requester i uses bits [i*AW +: AW]
- `req_wdata` in NREQ*DW: packed write data, packed the same way
- `done` out NREQ: one-hot, one-cycle completion pulse
- `rsp_rdata` out DW: read data; valid while `done` is high
- `rsp_err` out 1: error flag; valid while `done` is high
- `psel`, `penable`, `pwrite` out 1: APB control signals
- `paddr` out AW: APB address
- `pwdata` out DW: APB write data
- `prdata` in DW: APB read data
- `pready`, `pslverr` in 1: APB ready and error

## Operation
- State machine states: IDLE, SETUP, ACCESS.
- IDLE
  - If any `req` bit is high, pick the winner.
  - The search starts at `last_gnt+1` and wraps modulo NREQ.
  - Latch the winner's index, write flag, address and wdata into internal registers.
  - Go to SETUP.
- SETUP (exactly one cycle)
  - `psel`=1, `penable`=0; `pwrite`/`paddr`/`pwdata` driven from the latched registers.
  - Go to ACCESS.
- ACCESS
  - `psel`=1, `penable`=1; address, data and control held stable.
  - Each cycle with `pready`=0 increments `to_cnt` (width $clog2(TIMEOUT+1)).
- ACCESS completes normally when `pready`=1 is sampled:
  - `done[idx]` pulses.
  - `rsp_err`=`pslverr`.
  - `rsp_rdata`=`prdata` for a read, 0 for a write.
  - `last_gnt` <= idx; `to_cnt` cleared; go to IDLE.
- ACCESS times out when `to_cnt` reaches TIMEOUT with `pready` still 0:
  - `done[idx]` pulses with `rsp_err`=1, `rsp_rdata`=0.
  - Go to IDLE with `last_gnt` updated.
- Outputs are registered.
  - `psel`/`penable` drop in the cycle `done` is high.
  - At least one IDLE cycle separates consecutive transfers.
- Requester side effects:
  - Changes to `req`/fields after the latch are ignored for the current transfer.
  - A requester that drops `req` mid-transfer still receives `done`.
  - A requester's `req` is not re-considered in the cycle its `done` is high; it must deassert, or it is treated as a new request.
- Only the latched fields drive the bus; unselected requesters never affect `paddr`/`pwdata`.

## Timing
- Reset values:
  - `psel`=`penable`=`pwrite`=0, `paddr`=0, `pwdata`=0
  - `done`=0, `rsp_rdata`=0, `rsp_err`=0
  - state=IDLE, `to_cnt`=0, `last_gnt`=NREQ-1 (so requester 0 wins first)
- Reset during SETUP or ACCESS:
  - Bus is released at the next edge.
  - No `done` is issued and the transfer is dropped.
- Latency from `req` sampled in IDLE (edge 0):
  - SETUP at edge 1, ACCESS at edge 2.
  - Against a zero-wait slave (slave raises `pready` within the first ACCESS cycle), `done` is high after edge 3.
  - Each wait state adds 1 cycle.
  - Timeout case: `done` after edge 2+TIMEOUT.
- Maximum throughput: one transfer per 4 cycles with a zero-wait slave.
- `pslverr` is sampled only with `pready`=1 in ACCESS; ignored otherwise.
- Simultaneous requests: strict rotation. With all NREQ requesters continuously requesting, each is served once per NREQ transfers.

## Test plan
- Single write then read, requester 1:
  - Stimulus: write `0x0000_0010` ← `0xDEAD_BEEF`, then read the same address.
  - Required: `done`=`0b0010` each time; `psel`/`penable` sequence 10→11→00; read `rsp_rdata`=`0xDEAD_BEEF`, `rsp_err`=0.
- All 4 requesters raise `req` in the same cycle after reset:
  - Required: completion order 0,1,2,3.
  - Then re-request 0 and 2 together: order 0,2.
- Out-of-range access, requester 3 writes address `0x0000_0080`:
  - Required: `done[3]`=1, `rsp_err`=1; no other requester's state is affected.
- Timeout, `pready` tied low, TIMEOUT=16:
  - Required: `done` exactly 18 cycles after the request is sampled (2 + TIMEOUT); `rsp_err`=1, `rsp_rdata`=0; `psel`=0 in the following cycle.
- Reset mid-ACCESS:
  - Assert `prst` for 1 cycle during ACCESS.
  - Required: `psel`=`penable`=`done`=0 after that edge. The next request from requester 0 completes normally.
- Fields changed mid-transfer:
  - Change `req_addr`/`req_wdata` during ACCESS.
  - Required: `paddr`/`pwdata` stay at the latched values until `done`.

Source files
------------

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter sharing one APB3 master port among NREQ requesters,
// one transfer in flight, with forced termination of unacknowledged accesses.
//   state  | meaning
//   IDLE   | no transfer; winner fields latched on exit
//   SETUP  | SETUP phase (psel=1, penable=0) registered on the next edge
//   ACCESS | bus in SETUP then ACCESS; ends on pready or timeout
module apb_master_arbiter #(
  parameter int NREQ    = 4,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic               pclk,
  input  logic               prst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    req_write,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    done,
  output logic [DW-1:0]      rsp_rdata,
  output logic               rsp_err,
  output logic               psel,
  output logic               penable,
  output logic               pwrite,
  output logic [AW-1:0]      paddr,
  output logic [DW-1:0]      pwdata,
  input  logic [DW-1:0]      prdata,
  input  logic               pready,
  input  logic               pslverr
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state, state_nxt;

  logic [IW-1:0]   last_gnt, idx, win, cand;
  logic            win_vld;
  logic [TW-1:0]   to_cnt;
  logic [NREQ-1:0] eligible;
  logic            timeout_hit, finish;
  logic            psel_nxt, penable_nxt, err_nxt;
  logic [NREQ-1:0] done_nxt;
  logic [DW-1:0]   rdata_nxt;

  // A requester whose done is showing is still holding req; skip it this cycle.
  assign eligible = req & ~done;

  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    cand    = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = IW'((int'(last_gnt) + k) % NREQ);
      if (eligible[cand]) begin
        win     = cand;
        win_vld = 1'b1;
      end
    end
  end

  // pready is only meaningful once penable is actually on the bus.
  assign timeout_hit = penable && !pready && (to_cnt == TW'(TIMEOUT - 1));
  assign finish      = (state == ACCESS) && penable && (pready || timeout_hit);

  always_ff @(posedge pclk) begin
    if (prst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_vld) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (finish) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    psel_nxt    = 1'b0;
    penable_nxt = 1'b0;
    done_nxt    = '0;
    err_nxt     = 1'b0;
    rdata_nxt   = '0;
    case (state)
      SETUP:  psel_nxt = 1'b1;
      ACCESS: begin
        psel_nxt    = !finish;
        penable_nxt = !finish;
        if (finish) begin
          done_nxt[idx] = 1'b1;
          err_nxt       = pready ? pslverr : 1'b1;
          if (pready && !pwrite) rdata_nxt = prdata;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      psel      <= 1'b0;
      penable   <= 1'b0;
      done      <= '0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      idx       <= '0;
      last_gnt  <= IW'(NREQ - 1);
      to_cnt    <= '0;
    end else begin
      psel      <= psel_nxt;
      penable   <= penable_nxt;
      done      <= done_nxt;
      rsp_err   <= err_nxt;
      rsp_rdata <= rdata_nxt;
      if (state == IDLE && win_vld) begin
        idx    <= win;
        pwrite <= req_write[win];
        paddr  <= req_addr[int'(win)*AW +: AW];
        pwdata <= req_wdata[int'(win)*DW +: DW];
      end
      if (finish) begin
        last_gnt <= idx;
        to_cnt   <= '0;
      end else if (state == ACCESS && penable && !pready) begin
        to_cnt <= to_cnt + TW'(1);
      end
    end
  end
endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: APB memory slave with wait/stall control and a
// transaction-level model of round-robin order, latency and responses.
module tb_apb_master_arbiter;
  localparam int NREQ = 4, AW = 32, DW = 32, TIMEOUT = 16;

  logic               pclk, prst;
  logic [NREQ-1:0]    req, req_write, done;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [DW-1:0]      rsp_rdata, pwdata, prdata;
  logic [AW-1:0]      paddr;
  logic               rsp_err, psel, penable, pwrite, pready, pslverr, in_range;

  apb_master_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .pclk(pclk), .prst(prst), .req(req), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .done(done),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
    .pready(pready), .pslverr(pslverr));

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  // Slave: 32 words at 0x00..0x7C, error above; wait_cfg wait states or stall.
  logic [31:0] mem [32];
  int          wcnt;
  bit          stall;
  int          wait_cfg;
  assign in_range = paddr < 32'h80;
  assign pready   = psel && penable && !stall && (wcnt >= wait_cfg);
  assign prdata   = in_range ? mem[paddr[6:2]] : '0;
  assign pslverr  = !in_range;
  always @(posedge pclk) begin
    if (psel && penable && !pready) wcnt <= wcnt + 1;
    else                            wcnt <= 0;
    if (psel && penable && pready && pwrite && in_range) mem[paddr[6:2]] <= pwdata;
  end

  logic [31:0] exp_mem [32];
  int          last_m, n_cmp, n_err;
  logic        f_wr   [NREQ];
  logic [31:0] f_addr [NREQ];
  logic [31:0] f_data [NREQ];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_rsp(input int i, output logic [31:0] rd, output logic er);
    logic inr;
    inr = f_addr[i] < 32'h80;
    er  = !inr || stall;
    rd  = '0;
    if (inr && !stall) begin
      if (f_wr[i]) exp_mem[f_addr[i][6:2]] = f_data[i];
      else         rd = exp_mem[f_addr[i][6:2]];
    end
  endtask

  function automatic int next_rr(input logic [NREQ-1:0] pend);
    for (int k = 1; k <= NREQ; k++)
      if (pend[(last_m + k) % NREQ]) return (last_m + k) % NREQ;
    return 0;
  endfunction

  task automatic apply(input int i);
    req_write[i]            = f_wr[i];
    req_addr[i*AW +: AW]    = f_addr[i];
    req_wdata[i*DW +: DW]   = f_data[i];
  endtask

  task automatic rand_fields(input int i);
    f_wr[i]   = 1'($urandom % 2);
    f_addr[i] = 32'($urandom_range(0, 31)) * 4;
    if ($urandom % 8 == 0) f_addr[i] = f_addr[i] + 32'h80;
    f_data[i] = $urandom;
  endtask

  // Lone request with the arbiter idle: checks phases, held fields, latency, response.
  task automatic do_xfer(input int i, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data, input int w);
    int lat, c;
    logic [31:0] erd;
    logic eer;
    logic [1:0] pe;
    f_wr[i] = wr; f_addr[i] = addr; f_data[i] = data; wait_cfg = w;
    lat = 4 + (stall ? TIMEOUT - 1 : w);
    apply(i);
    req[i] = 1'b1;
    c = 0;
    while (c < lat + 8) begin
      @(negedge pclk);
      c++;
      pe = (c == 1 || c >= lat) ? 2'b00 : ((c == 2) ? 2'b10 : 2'b11);
      chk("bus_phase", 32'({psel, penable}), 32'(pe));
      if (psel) begin
        chk("paddr_held", paddr, addr);
        chk("pwdata_held", pwdata, data);
        chk("pwrite_held", 32'(pwrite), 32'(wr));
      end
      if (c >= 2) begin
        req_addr[i*AW +: AW]  = $urandom;
        req_wdata[i*DW +: DW] = $urandom;
        req_write[i]          = ~wr;
      end
      if (done !== '0) break;
    end
    chk("latency", 32'(c), 32'(lat));
    chk("done_onehot", 32'(done), 32'(1) << i);
    model_rsp(i, erd, eer);
    chk("rsp_err", 32'(rsp_err), 32'(eer));
    chk("rsp_rdata", rsp_rdata, erd);
    last_m = i;
    req[i] = 1'b0;
    @(negedge pclk);
    chk("psel_after_done", 32'(psel), 32'd0);
    chk("done_cleared", 32'(done), 32'd0);
  endtask

  // Several requesters raised together: checks rotation order and back-to-back spacing.
  task automatic multi(input logic [NREQ-1:0] mask, input int w);
    int c, prev, ei;
    logic [NREQ-1:0] pend;
    logic [31:0] erd;
    logic eer;
    wait_cfg = w;
    pend = mask;
    for (int i = 0; i < NREQ; i++) if (mask[i]) begin rand_fields(i); apply(i); end
    req = req | mask;
    c = 0; prev = 0;
    while (pend != '0 && c < 400) begin
      @(negedge pclk);
      c++;
      if (done != '0) begin
        ei = next_rr(pend);
        chk("rr_order", 32'(done), 32'(1) << ei);
        chk("rr_spacing", 32'(c - prev), 32'(4 + w));
        model_rsp(ei, erd, eer);
        chk("rr_err", 32'(rsp_err), 32'(eer));
        chk("rr_rdata", rsp_rdata, erd);
        last_m = ei;
        pend[ei] = 1'b0;
        req = req & ~done;
        prev = c;
      end
    end
    chk("multi_complete", 32'(pend), 32'd0);
    req = '0;
    @(negedge pclk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_err = 0; stall = 1'b0; wait_cfg = 0; last_m = NREQ - 1;
    prst = 1'b1; req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge pclk);
    chk("rst_psel", 32'(psel), 32'd0);
    chk("rst_penable", 32'(penable), 32'd0);
    chk("rst_pwrite", 32'(pwrite), 32'd0);
    chk("rst_paddr", paddr, 32'd0);
    chk("rst_pwdata", pwdata, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    prst = 1'b0;
    @(negedge pclk);

    for (int a = 0; a < 32; a++) do_xfer(a % NREQ, 1'b1, 32'(a * 4), $urandom, a % 3);

    do_xfer(1, 1'b1, 32'h10, 32'hDEAD_BEEF, 0);
    do_xfer(1, 1'b0, 32'h10, 32'h0, 0);
    chk("read_back", exp_mem[4], 32'hDEAD_BEEF);

    prst = 1'b1; @(negedge pclk); prst = 1'b0; last_m = NREQ - 1;
    @(negedge pclk);
    multi(4'b1111, 0);
    multi(4'b0101, 0);

    do_xfer(3, 1'b1, 32'h80, 32'h1234_5678, 0);

    stall = 1'b1;
    do_xfer(2, 1'b0, 32'h10, 32'h0, 0);
    stall = 1'b0;

    // Reset in the middle of a stalled ACCESS drops the transfer silently.
    stall = 1'b1;
    f_wr[0] = 1'b0; f_addr[0] = 32'h10; f_data[0] = 32'h0; apply(0);
    req[0] = 1'b1;
    repeat (3) @(negedge pclk);
    chk("pre_rst_penable", 32'(penable), 32'd1);
    prst = 1'b1; req[0] = 1'b0;
    @(negedge pclk);
    prst = 1'b0;
    chk("midrst_psel", 32'(psel), 32'd0);
    chk("midrst_penable", 32'(penable), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    stall = 1'b0; last_m = NREQ - 1;
    @(negedge pclk);
    chk("midrst_no_done", 32'(done), 32'd0);
    do_xfer(0, 1'b0, 32'h10, 32'h0, 0);

    for (int n = 0; n < 24; n++) begin
      if ($urandom % 2 == 0) begin
        int i;
        i = $urandom_range(0, NREQ - 1);
        rand_fields(i);
        do_xfer(i, f_wr[i], f_addr[i], f_data[i], $urandom_range(0, 3));
      end else begin
        logic [NREQ-1:0] m;
        m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
        multi(m, $urandom_range(0, 2));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
